// File: rtl/pdm_cic_decim_pkg.sv
// pdm_cic_decim_pkg: shared constants, widths and stage mode for the PDM CIC decimator
package pdm_cic_decim_pkg;
    localparam int C_DECIM_LOG2_DEF = 5;
    localparam int C_ORDER_FIX      = 3;
    localparam int C_LATENCY        = 7;
    localparam int PCM_MAX          = 32767;
    localparam int PCM_MIN          = -32768;

    typedef enum logic {MODE_INT, MODE_COMB} cic_mode_t;

    // Internal arithmetic width for decimation log2 l: order 3 growth plus sign
    function automatic int cic_w(input int l);
        return 3 * l + 2;
    endfunction
endpackage

// File: rtl/pdm_cic_decim_stage.sv
// cic_stage: one W-bit CIC section, integrator (q += din) or comb (q = din - previous din)
//   clk  : clock
//   rst  : asynchronous active-high reset, clears q and the comb delay
//   en   : stage advances when high
//   din  : stage input
//   q    : registered stage output
module cic_stage
    import pdm_cic_decim_pkg::*;
#(
    parameter int        W    = 17,
    parameter cic_mode_t MODE = MODE_INT
) (
    input  logic         clk,
    input  logic         rst,
    input  logic         en,
    input  logic [W-1:0] din,
    output logic [W-1:0] q
);
    logic [W-1:0] z;

    // Sums and differences wrap modulo 2**W; the comb chain cancels the wrap exactly
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            q <= '0;
            z <= '0;
        end else if (en) begin
            q <= (MODE == MODE_INT) ? q + din : din - z;
            z <= din;
        end
    end
endmodule

// File: rtl/pdm_cic_decim.sv
// pdm_cic_decim: third-order CIC decimator, 1-bit PDM in, saturated signed PCM out
//   CK_i      : system clock (48 MHz)
//   ARST_i    : asynchronous active-high reset
//   MIC_EE_i  : one-cycle strobe per mic clock, PDM_DAT_i valid in that cycle
//   PDM_DAT_i : PDM bit, 1 -> +1, 0 -> -1
//   PCM_o     : signed decimated sample, saturated to 3*C_DECIM_LOG2+1 bits
//   PCM_EE_o  : one-cycle strobe, PCM_o updated in this cycle
module pdm_cic_decim
    import pdm_cic_decim_pkg::*;
#(
    parameter int C_DECIM_LOG2 = C_DECIM_LOG2_DEF,
    parameter int C_ORDER      = C_ORDER_FIX
) (
    input  logic                  CK_i,
    input  logic                  ARST_i,
    input  logic                  MIC_EE_i,
    input  logic                  PDM_DAT_i,
    output logic [3*C_DECIM_LOG2:0] PCM_o,
    output logic                  PCM_EE_o
);
    localparam int W = cic_w(C_DECIM_LOG2);
    localparam int P = W - 1;

    if (C_ORDER != C_ORDER_FIX) begin : g_bad_order
        $error("pdm_cic_decim supports only C_ORDER = 3");
    end

    logic [W-1:0]              d, int1, int2, int3, c1, c2, c3;
    logic                      en1, en2, en3, dt1, dt2, dt3;
    logic [C_DECIM_LOG2-1:0]   dec_ctr;

    always_ff @(posedge CK_i or posedge ARST_i) begin
        if (ARST_i) begin
            d        <= '0;
            en1      <= 1'b0;
            en2      <= 1'b0;
            en3      <= 1'b0;
            dt1      <= 1'b0;
            dt2      <= 1'b0;
            dt3      <= 1'b0;
            dec_ctr  <= '0;
            PCM_EE_o <= 1'b0;
        end else begin
            en1      <= MIC_EE_i;
            en2      <= en1;
            en3      <= en2;
            dt1      <= en3 && (dec_ctr == '1);
            dt2      <= dt1;
            dt3      <= dt2;
            PCM_EE_o <= dt3;
            if (MIC_EE_i)
                d <= {{(W-1){~PDM_DAT_i}}, 1'b1};
            if (en3)
                dec_ctr <= dec_ctr + 1'b1;
        end
    end

    cic_stage #(.W(W), .MODE(MODE_INT))  u_int1 (.clk(CK_i), .rst(ARST_i), .en(en1), .din(d),    .q(int1));
    cic_stage #(.W(W), .MODE(MODE_INT))  u_int2 (.clk(CK_i), .rst(ARST_i), .en(en2), .din(int1), .q(int2));
    cic_stage #(.W(W), .MODE(MODE_INT))  u_int3 (.clk(CK_i), .rst(ARST_i), .en(en3), .din(int2), .q(int3));
    cic_stage #(.W(W), .MODE(MODE_COMB)) u_cmb1 (.clk(CK_i), .rst(ARST_i), .en(dt1), .din(int3), .q(c1));
    cic_stage #(.W(W), .MODE(MODE_COMB)) u_cmb2 (.clk(CK_i), .rst(ARST_i), .en(dt2), .din(c1),   .q(c2));
    cic_stage #(.W(W), .MODE(MODE_COMB)) u_cmb3 (.clk(CK_i), .rst(ARST_i), .en(dt3), .din(c2),   .q(c3));

    // C3 spans -2**(P-1)..+2**(P-1); only the positive full-scale value needs clamping
    assign PCM_o = (c3 == {2'b01, {(P-1){1'b0}}}) ? {1'b0, {(P-1){1'b1}}} : c3[P-1:0];
endmodule

// File: tb/tb_pdm_cic_decim.sv
// tb_pdm_cic_decim: table-driven and scoreboard bench for pdm_cic_decim
module tb_pdm_cic_decim;
    import pdm_cic_decim_pkg::*;

    localparam int L = C_DECIM_LOG2_DEF;
    localparam int R = 1 << L;
    localparam int W = cic_w(L);
    localparam int P = 3 * L + 1;

    logic         CK_i = 1'b0;
    logic         ARST_i = 1'b0;
    logic         MIC_EE_i = 1'b0;
    logic         PDM_DAT_i = 1'b0;
    logic [P-1:0] PCM_o;
    logic         PCM_EE_o;

    always #5 CK_i = ~CK_i;

    pdm_cic_decim #(.C_DECIM_LOG2(L), .C_ORDER(3)) dut (
        .CK_i(CK_i), .ARST_i(ARST_i), .MIC_EE_i(MIC_EE_i), .PDM_DAT_i(PDM_DAT_i),
        .PCM_o(PCM_o), .PCM_EE_o(PCM_EE_o)
    );

    typedef struct {
        logic signed [P-1:0] val;
        int                  due;
    } exp_t;

    typedef struct {
        int pat;
        int n;
        int gap;
        int pulses;
        bit steady;
        int steady_val;
    } vec_t;

    exp_t         sb[$];
    exp_t         mon_e;
    int           checks = 0;
    int           errors = 0;
    int           ncyc = 0;
    int           pulses = 0;
    int           last_mic = -100;
    bit           prev_ee = 1'b0;
    bit           cur_steady = 1'b0;
    int           cur_val = 0;
    logic [W-1:0] m_i1, m_i2, m_i3, m_z1, m_z2, m_z3;
    int           m_cnt;

    task automatic check(input string name, input int act, input int exp);
        checks++;
        if (act != exp) begin
            errors++;
            $display("FAIL %s: got %0d expected %0d (cycle %0d)", name, act, exp, ncyc);
        end
    endtask

    always @(negedge CK_i) begin
        ncyc++;
        if (MIC_EE_i) begin
            assert (ncyc - last_mic >= 8) else $error("MIC_EE_i spacing below 8 cycles");
            last_mic = ncyc;
        end
        if (PCM_EE_o) begin
            check("pcm_ee_consecutive", int'(prev_ee), 0);
            pulses++;
            check("pcm_ee_expected", int'(sb.size() > 0), 1);
            if (sb.size() > 0) begin
                mon_e = sb.pop_front();
                check("pcm_value", int'($signed(PCM_o)), int'(mon_e.val));
                check("pcm_latency", ncyc, mon_e.due);
            end
            if (cur_steady && pulses >= 3)
                check("pcm_steady", int'($signed(PCM_o)), cur_val);
        end
        prev_ee = PCM_EE_o;
    end

    task automatic model_clear();
        m_i1 = '0; m_i2 = '0; m_i3 = '0;
        m_z1 = '0; m_z2 = '0; m_z3 = '0;
        m_cnt = 0;
    endtask

    // One sample: strobe for a cycle, advance the reference CIC, leave `gap` cycles to the next strobe
    task automatic send(input bit b, input int gap);
        logic [W-1:0] dv, c1, c2, c3;
        exp_t e;
        @(posedge CK_i);
        #1;
        MIC_EE_i  = 1'b1;
        PDM_DAT_i = b;
        dv = b ? W'(1) : {W{1'b1}};
        m_i1 = m_i1 + dv;
        m_i2 = m_i2 + m_i1;
        m_i3 = m_i3 + m_i2;
        m_cnt++;
        if (m_cnt == R) begin
            m_cnt = 0;
            c1 = m_i3 - m_z1; m_z1 = m_i3;
            c2 = c1 - m_z2;   m_z2 = c1;
            c3 = c2 - m_z3;   m_z3 = c2;
            if ($signed(c3) > PCM_MAX)
                e.val = P'(PCM_MAX);
            else if ($signed(c3) < PCM_MIN)
                e.val = P'(PCM_MIN);
            else
                e.val = c3[P-1:0];
            e.due = ncyc + 1 + C_LATENCY;
            sb.push_back(e);
        end
        @(posedge CK_i);
        #1;
        MIC_EE_i = 1'b0;
        repeat (gap - 2) @(posedge CK_i);
    endtask

    task automatic do_reset();
        #1;
        ARST_i   = 1'b1;
        MIC_EE_i = 1'b0;
        repeat (2) @(posedge CK_i);
        #1;
        ARST_i = 1'b0;
        sb.delete();
        pulses = 0;
        model_clear();
        @(negedge CK_i);
        check("rst_pcm", int'($signed(PCM_o)), 0);
        check("rst_pcm_ee", int'(PCM_EE_o), 0);
    endtask

    initial begin
        vec_t vt[4];
        bit   b;
        vt[0] = '{1, 128,  12, 4,   1'b1, PCM_MAX};
        vt[1] = '{0, 128,  12, 4,   1'b1, PCM_MIN};
        vt[2] = '{2, 320,  12, 10,  1'b1, 0};
        vt[3] = '{3, 8000, 8,  250, 1'b0, 0};
        for (int v = 0; v < 4; v++) begin
            do_reset();
            cur_steady = vt[v].steady;
            cur_val    = vt[v].steady_val;
            for (int i = 0; i < vt[v].n; i++) begin
                case (vt[v].pat)
                    0:       b = 1'b0;
                    1:       b = 1'b1;
                    2:       b = (i % 2 == 0);
                    default: b = ($urandom_range(0, 1) != 0);
                endcase
                if (i == R - 1)
                    check("pcm_before_first", int'($signed(PCM_o)), 0);
                send(b, vt[v].gap);
            end
            repeat (12) @(posedge CK_i);
            check("pulse_count", pulses, vt[v].pulses);
            check("scoreboard_drained", sb.size(), 0);
        end

        // Reset three cycles after the block-ending strobe must swallow that block
        do_reset();
        cur_steady = 1'b0;
        for (int i = 0; i < R; i++)
            send(1'b1, (i == R - 1) ? 4 : 12);
        do_reset();
        repeat (20) @(posedge CK_i);
        check("abort_no_pulse", pulses, 0);
        check("abort_pcm", int'($signed(PCM_o)), 0);
        for (int i = 0; i < R; i++)
            send(1'b1, 12);
        repeat (12) @(posedge CK_i);
        check("post_abort_pulses", pulses, 1);
        check("post_abort_drained", sb.size(), 0);

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end
endmodule
